axis_hblur3: RTL and testbench
==============================

Name: axis_hblur3

Overview:
- AXI-Stream image processing stage. Sits between the image VIP source (master side) and the image VIP sink (slave side).
- Applies a horizontal 3-tap [1 2 1]/4 low-pass filter to every line, independently per byte lane. Edge pixels are replicated at line ends.
- tlast (end of line) and tuser (start of frame) travel with each pixel. Output pixel count per line equals input pixel count.

Parameters:
- DATA_BYTES, 1, bytes per pixel; each byte is filtered as an independent channel.
- DATA_BITS, DATA_BYTES*8, pixel bus width.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- axis_s_data_i  in  DATA_BITS  input pixel
- axis_s_valid_i  in  1  input valid
- axis_s_ready_o  out  1  input ready
- axis_s_last_i  in  1  last pixel of line
- axis_s_user_i  in  1  first pixel of frame
- axis_m_data_o  out  DATA_BITS  filtered pixel
- axis_m_valid_o  out  1  output valid
- axis_m_ready_i  in  1  output ready
- axis_m_last_o  out  1  last pixel of line
- axis_m_user_o  out  1  start of frame
- sof_err_o  out  1  sticky: tuser seen on a non-first pixel of a line

Behaviour:
- Reset (async): state=EMPTY; axis_m_valid_o=0, axis_m_last_o=0, axis_m_user_o=0, axis_m_data_o=0, sof_err_o=0. Held pixels are cleared and a partial line is dropped. axis_s_ready_o=0 while rstn_i=0.
- Output register: a single slot. adv = !axis_m_valid_o || axis_m_ready_i.
  - axis_s_ready_o = rstn_i && adv && state!=FLUSH. This is a combinational path from axis_m_ready_i.
  - acc = axis_s_valid_i && axis_s_ready_o.
- When adv=1 and nothing new is loaded, axis_m_valid_o drops to 0.
- Output stability: while axis_m_valid_o=1 && axis_m_ready_i=0, all axis_m_* outputs hold stable.
- Held registers: prv, cur (DATA_BITS each) and cur_user.
- Filter f(a,b,c) per byte lane = (a + 2b + c + 2) >> 2, computed in 10 bits. Result always fits in 8 bits; no saturation logic.
- State EMPTY (no pixel held), on acc of pixel p with last L and user U:
  - L=1 (1-pixel line): load out = p, last=1, user=U. Stay EMPTY.
  - L=0: prv=p, cur=p, cur_user=U. Go to HOLD. No output is produced.
- State HOLD, on acc of pixel n:
  - Load out = f(prv, cur, n), last=0, user=cur_user.
  - Then prv=cur, cur=n, cur_user=axis_s_user_i.
  - If axis_s_last_i=1, go to FLUSH; otherwise stay HOLD.
  - If axis_s_user_i=1, set sof_err_o=1. The pixel is still processed normally.
- State FLUSH: input is stalled. When adv=1:
  - Load out = f(prv, cur, cur), last=1, user=cur_user.
  - Go to EMPTY.
- Latency: output i is loaded in the cycle pixel i+1 is accepted. The final pixel of a line is loaded on the first adv cycle after the last input is accepted.
- Throughput: 1 pixel/cycle within a line, with one bubble cycle on input per line (FLUSH).
- tuser on the first pixel of a line propagates to that line's first output. tlast is regenerated exactly on the last output of each line.
- sof_err_o is cleared only by reset.
- Simultaneous events: output consumption and a new load in the same cycle is allowed (adv=1) and gives back-to-back valid with no gap.

Test Plan:
- Line 10,20,30,40 (user on 10, last on 40), m_ready=1 → outputs 13(user=1), 20, 30, 38(last=1); s_ready low for exactly 1 cycle after 40 is accepted.
- Single-pixel line 77 with last=1, user=1 → output 77, last=1, user=1, 1 cycle after accept; state returns to EMPTY.
- DATA_BYTES=2, line 0x00FF, 0xFF00 (last) → 0x40BF, then 0xBF40 (last=1); the byte lanes are independent.
- Line 255,255,255 → 255, 255, 255; no overflow wrap.
- Line 1..8 with m_ready low for cycles 3-7 → s_ready low, output held stable, no loss or duplication; outputs match the unstalled run.
- tuser on the 3rd pixel of a line → sof_err_o=1 thereafter; data unaffected. Then rstn_i pulse mid-line → sof_err_o=0, valid=0; the next line filters correctly from an EMPTY start.

Source files
------------

// File: rtl/axis_hblur3.sv
// axis_hblur3: AXI-Stream horizontal [1 2 1]/4 blur, one channel per byte lane.
// Line ends are handled by replicating the edge pixel.
// tuser and tlast follow each pixel. sof_err_o flags tuser seen inside a line.
//
// state  | meaning
// -------+----------------------------------------------------------------
// EMPTY  | no pixel of the current line is held
// HOLD   | prv/cur hold the two most recent pixels of the current line
// FLUSH  | last pixel accepted; input stalled until its output can load
module axis_hblur3 #(
    parameter int DATA_BYTES = 1,
    parameter int DATA_BITS  = DATA_BYTES * 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [DATA_BITS-1:0] axis_s_data_i,
    input  logic                 axis_s_valid_i,
    output logic                 axis_s_ready_o,
    input  logic                 axis_s_last_i,
    input  logic                 axis_s_user_i,
    output logic [DATA_BITS-1:0] axis_m_data_o,
    output logic                 axis_m_valid_o,
    input  logic                 axis_m_ready_i,
    output logic                 axis_m_last_o,
    output logic                 axis_m_user_o,
    output logic                 sof_err_o
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HOLD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   prv_q, cur_q;
    logic                   cur_user_q;
    logic [DATA_BITS-1:0]   out_data_q;
    logic                   out_valid_q, out_last_q, out_user_q;
    logic                   sof_err_q;

    logic                   adv, acc;
    logic                   load;
    logic [DATA_BITS-1:0]   load_data;
    logic                   load_last, load_user;
    logic                   cap_first, shift_in, err_set;

    // (a + 2b + c + 2) >> 2 per byte lane; the 10-bit sum never exceeds 1022,
    // so the quotient always fits back into 8 bits.
    function automatic logic [DATA_BITS-1:0] blur(
        input logic [DATA_BITS-1:0] a,
        input logic [DATA_BITS-1:0] b,
        input logic [DATA_BITS-1:0] c
    );
        logic [DATA_BITS-1:0] r;
        logic [9:0]           s;
        r = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            s = {2'b00, a[8*i +: 8]} + {1'b0, b[8*i +: 8], 1'b0}
              + {2'b00, c[8*i +: 8]} + 10'd2;
            r[8*i +: 8] = s[9:2];
        end
        return r;
    endfunction

    assign adv            = !out_valid_q || axis_m_ready_i;
    assign axis_s_ready_o = rstn_i && adv && (state_q != S_FLUSH);
    assign acc            = axis_s_valid_i && axis_s_ready_o;

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (acc && !axis_s_last_i) state_d = S_HOLD;
            S_HOLD:  if (acc && axis_s_last_i)  state_d = S_FLUSH;
            S_FLUSH: if (adv)                   state_d = S_EMPTY;
            default:                            state_d = S_EMPTY;
        endcase
    end

    // Per-state actions: what to load into the output slot and the held pixels
    always_comb begin
        load      = 1'b0;
        load_data = '0;
        load_last = 1'b0;
        load_user = 1'b0;
        cap_first = 1'b0;
        shift_in  = 1'b0;
        err_set   = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (acc) begin
                    if (axis_s_last_i) begin
                        load      = 1'b1;
                        load_data = axis_s_data_i;
                        load_last = 1'b1;
                        load_user = axis_s_user_i;
                    end else begin
                        cap_first = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (acc) begin
                    load      = 1'b1;
                    load_data = blur(prv_q, cur_q, axis_s_data_i);
                    load_user = cur_user_q;
                    shift_in  = 1'b1;
                    err_set   = axis_s_user_i;
                end
            end
            S_FLUSH: begin
                if (adv) begin
                    load      = 1'b1;
                    load_data = blur(prv_q, cur_q, cur_q);
                    load_last = 1'b1;
                    load_user = cur_user_q;
                end
            end
            default: ;
        endcase
    end

    // Held pixels of the current line
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            prv_q      <= '0;
            cur_q      <= '0;
            cur_user_q <= 1'b0;
        end else if (cap_first) begin
            prv_q      <= axis_s_data_i;
            cur_q      <= axis_s_data_i;
            cur_user_q <= axis_s_user_i;
        end else if (shift_in) begin
            prv_q      <= cur_q;
            cur_q      <= axis_s_data_i;
            cur_user_q <= axis_s_user_i;
        end
    end

    // Output slot; payload only changes on a load so it is stable under backpressure
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_user_q  <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= load_data;
            out_last_q  <= load_last;
            out_user_q  <= load_user;
        end else if (adv) begin
            out_valid_q <= 1'b0;
        end
    end

    // Sticky tuser-inside-line flag
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sof_err_q <= 1'b0;
        end else if (err_set) begin
            sof_err_q <= 1'b1;
        end
    end

    assign axis_m_data_o  = out_data_q;
    assign axis_m_valid_o = out_valid_q;
    assign axis_m_last_o  = out_last_q;
    assign axis_m_user_o  = out_user_q;
    assign sof_err_o      = sof_err_q;

endmodule

// File: tb/tb_axis_hblur3.sv
// Bench for axis_hblur3 with two byte lanes: per-line reference model,
// per-cycle stream/stability/sof_err compare, and directed literal checks.
module tb_axis_hblur3;

    localparam int DB = 2;
    localparam int W  = DB * 8;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic [W-1:0]  axis_s_data_i = '0;
    logic          axis_s_valid_i = 1'b0;
    logic          axis_s_ready_o;
    logic          axis_s_last_i = 1'b0;
    logic          axis_s_user_i = 1'b0;
    logic [W-1:0]  axis_m_data_o;
    logic          axis_m_valid_o;
    logic          axis_m_ready_i = 1'b1;
    logic          axis_m_last_o;
    logic          axis_m_user_o;
    logic          sof_err_o;

    axis_hblur3 #(.DATA_BYTES(DB), .DATA_BITS(W)) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .axis_s_data_i  (axis_s_data_i),
        .axis_s_valid_i (axis_s_valid_i),
        .axis_s_ready_o (axis_s_ready_o),
        .axis_s_last_i  (axis_s_last_i),
        .axis_s_user_i  (axis_s_user_i),
        .axis_m_data_o  (axis_m_data_o),
        .axis_m_valid_o (axis_m_valid_o),
        .axis_m_ready_i (axis_m_ready_i),
        .axis_m_last_o  (axis_m_last_o),
        .axis_m_user_o  (axis_m_user_o),
        .sof_err_o      (sof_err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Entries are {user, last, data}
    logic [W+1:0] exp_q[$];
    logic [W+1:0] got_q[$];
    logic [W-1:0] line_d[$];
    logic         line_u[$];
    logic         m_sof = 1'b0;

    function automatic logic [W+1:0] pk(input logic u, input logic l, input logic [W-1:0] d);
        return {u, l, d};
    endfunction

    // Rounded weighted average of three neighbours, each byte on its own
    function automatic logic [W-1:0] fref(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        logic [W-1:0] r;
        int sa, sb, sc, s;
        r = '0;
        for (int i = 0; i < DB; i++) begin
            sa = int'(a[8*i +: 8]);
            sb = int'(b[8*i +: 8]);
            sc = int'(c[8*i +: 8]);
            s  = (sa + 2 * sb + sc + 2) / 4;
            r[8*i +: 8] = 8'(s);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, expv, $time);
        end
    endtask

    // Pixel j of a line completes output j-1; the last pixel also completes itself
    task automatic model_accept(input logic [W-1:0] d, input logic l, input logic u);
        int j;
        logic [W-1:0] left;
        line_d.push_back(d);
        line_u.push_back(u);
        j = line_d.size() - 1;
        if (j >= 1 && u) m_sof = 1'b1;
        if (j >= 1) begin
            left = (j >= 2) ? line_d[j-2] : line_d[j-1];
            exp_q.push_back(pk(line_u[j-1], 1'b0, fref(left, line_d[j-1], d)));
        end
        if (l) begin
            left = (j >= 1) ? line_d[j-1] : d;
            exp_q.push_back(pk(u, 1'b1, fref(left, d, d)));
            line_d.delete();
            line_u.delete();
        end
    endtask

    // Monitor: observes handshakes at the active edge and advances the model
    initial begin
        forever begin
            @(posedge clk_i);
            if (!rstn_i) begin
                exp_q.delete();
                line_d.delete();
                line_u.delete();
                m_sof = 1'b0;
            end else begin
                if (axis_m_valid_o && axis_m_ready_i) begin
                    got_q.push_back(pk(axis_m_user_o, axis_m_last_o, axis_m_data_o));
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                if (axis_s_valid_i && axis_s_ready_o)
                    model_accept(axis_s_data_i, axis_s_last_i, axis_s_user_i);
            end
        end
    end

    // Compare process, away from the active edge
    initial begin
        logic         hold_prev;
        logic [W+2:0] snap;
        hold_prev = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk_i);
            #3;
            if (!rstn_i) begin
                hold_prev = 1'b0;
            end else begin
                chk("sof_err", sof_err_o, m_sof);
                if (hold_prev)
                    chk("hold_stable", {axis_m_valid_o, axis_m_user_o, axis_m_last_o, axis_m_data_o}, snap);
                if (axis_m_valid_o && axis_m_ready_i) begin
                    if (exp_q.size() == 0)
                        chk("out_unexpected", 1, 0);
                    else
                        chk("out_stream", pk(axis_m_user_o, axis_m_last_o, axis_m_data_o), exp_q[0]);
                end
                hold_prev = axis_m_valid_o && !axis_m_ready_i;
                snap = {axis_m_valid_o, axis_m_user_o, axis_m_last_o, axis_m_data_o};
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic l, input logic u);
        int n;
        @(negedge clk_i);
        axis_s_valid_i = 1'b1;
        axis_s_data_i  = d;
        axis_s_last_i  = l;
        axis_s_user_i  = u;
        #2;
        n = 0;
        while (!axis_s_ready_o && n < 100) begin
            @(negedge clk_i);
            #2;
            n++;
        end
        if (n >= 100) begin
            chk("send_timeout", 0, 1);
            axis_s_valid_i = 1'b0;
        end else begin
            @(posedge clk_i);
            #1;
            axis_s_valid_i = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || axis_m_valid_o) && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic got_is(input string name, input int idx, input logic [W+1:0] expv);
        if (idx >= got_q.size()) chk(name, 32'hDEAD, expv);
        else                     chk(name, got_q[idx], expv);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk_i);
        #2;
        chk("rst_s_ready", axis_s_ready_o, 0);
        chk("rst_valid", axis_m_valid_o, 0);
        chk("rst_last_user_data", {axis_m_last_o, axis_m_user_o, axis_m_data_o}, 0);
        chk("rst_sof", sof_err_o, 0);
        @(negedge clk_i);
        rstn_i = 1'b1;

        // Basic line with edge replication
        got_q.delete();
        send(16'd10, 0, 1);
        send(16'd20, 0, 0);
        send(16'd30, 0, 0);
        send(16'd40, 1, 0);
        @(negedge clk_i); #2;
        chk("flush_bubble", axis_s_ready_o, 0);
        @(negedge clk_i); #2;
        chk("flush_over", axis_s_ready_o, 1);
        drain();
        chk("l1_count", got_q.size(), 4);
        got_is("l1_o0", 0, pk(1, 0, 16'd13));
        got_is("l1_o1", 1, pk(0, 0, 16'd20));
        got_is("l1_o2", 2, pk(0, 0, 16'd30));
        got_is("l1_o3", 3, pk(0, 1, 16'd38));

        // Single-pixel line
        got_q.delete();
        send(16'd77, 1, 1);
        @(negedge clk_i); #2;
        chk("single_valid", axis_m_valid_o, 1);
        chk("single_out", pk(axis_m_user_o, axis_m_last_o, axis_m_data_o), pk(1, 1, 16'd77));
        chk("single_empty_ready", axis_s_ready_o, 1);
        drain();
        chk("single_count", got_q.size(), 1);

        // Independent byte lanes
        got_q.delete();
        send(16'h00FF, 0, 0);
        send(16'hFF00, 1, 0);
        drain();
        got_is("lanes_o0", 0, pk(0, 0, 16'h40BF));
        got_is("lanes_o1", 1, pk(0, 1, 16'hBF40));

        // Full-scale values stay in range
        got_q.delete();
        send(16'hFFFF, 0, 0);
        send(16'hFFFF, 0, 0);
        send(16'hFFFF, 1, 0);
        drain();
        got_is("sat_o0", 0, pk(0, 0, 16'hFFFF));
        got_is("sat_o1", 1, pk(0, 0, 16'hFFFF));
        got_is("sat_o2", 2, pk(0, 1, 16'hFFFF));

        // Backpressure in the middle of a line
        got_q.delete();
        fork
            begin
                for (int i = 1; i <= 8; i++) send(W'(i), (i == 8), 0);
            end
            begin
                repeat (3) @(negedge clk_i);
                axis_m_ready_i = 1'b0;
                repeat (2) @(negedge clk_i);
                #2;
                chk("stall_s_ready", axis_s_ready_o, 0);
                chk("stall_valid", axis_m_valid_o, 1);
                repeat (3) @(negedge clk_i);
                axis_m_ready_i = 1'b1;
            end
        join
        drain();
        chk("stall_count", got_q.size(), 8);
        for (int i = 0; i < 8; i++)
            got_is("stall_data", i, pk(0, (i == 7), W'(i + 1)));

        // tuser inside a line
        got_q.delete();
        send(16'd5, 0, 0);
        send(16'd6, 0, 0);
        send(16'd7, 0, 1);
        send(16'd8, 1, 0);
        drain();
        chk("sof_err_set", sof_err_o, 1);
        got_is("err_o0", 0, pk(0, 0, 16'd5));
        got_is("err_o1", 1, pk(0, 0, 16'd6));
        got_is("err_o2", 2, pk(1, 0, 16'd7));
        got_is("err_o3", 3, pk(0, 1, 16'd8));

        // Reset in the middle of a line
        send(16'd50, 0, 0);
        send(16'd60, 0, 0);
        @(negedge clk_i);
        rstn_i = 1'b0;
        #2;
        chk("mid_rst_sof", sof_err_o, 0);
        chk("mid_rst_valid", axis_m_valid_o, 0);
        chk("mid_rst_s_ready", axis_s_ready_o, 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        got_q.delete();
        send(16'd10, 0, 1);
        send(16'd20, 0, 0);
        send(16'd30, 0, 0);
        send(16'd40, 1, 0);
        drain();
        chk("post_rst_count", got_q.size(), 4);
        got_is("post_o0", 0, pk(1, 0, 16'd13));
        got_is("post_o3", 3, pk(0, 1, 16'd38));
        chk("post_rst_sof", sof_err_o, 0);

        repeat (2) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
